// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: little-endian byte-addressed store/load
// with alignment/range checking and a fixed, parameterized response latency.

module data_mem_byte_lane (
   input  logic       en,
   input  logic [7:0] new_b,
   input  logic [7:0] old_b,
   output logic [7:0] out_b
);
   assign out_b = en ? new_b : old_b;
endmodule

module data_mem_responder #(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 512,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic             reqWrite,
   input  logic [WIDTH-1:0] reqAddress,
   input  logic [WIDTH-1:0] reqWriteData,
   input  logic [1:0]       reqSize,
   input  logic             reqUnsigned,
   output logic             respValid,
   input  logic             respReady,
   output logic [WIDTH-1:0] respReadData,
   output logic             respError
);
   localparam int NB = WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(DEPTH);
   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DEPTH * NB);
   localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic             live;
   logic             cap_wr, cap_uns;
   logic [WIDTH-1:0] cap_addr, cap_wdata;
   logic [1:0]       cap_size;

   logic             acc, commit, wr, uns, misal, oor, err;
   logic [WIDTH-1:0] addr, wdata, word, sh, ld, wsh, wmerge;
   logic [1:0]       size;
   logic [LB-1:0]    lane;
   logic [IW-1:0]    idx;
   logic [NB-1:0]    sz_mask, be;

   logic [WIDTH-1:0] mem [DEPTH];

   assign reqReady  = live && (state == IDLE);
   assign respValid = (state == RESP);
   assign acc       = reqValid && reqReady;
   assign commit    = (acc && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd0));

   // With LATENCY=1 the access resolves on the accept edge, so decode the live inputs.
   assign wr    = (state == IDLE) ? reqWrite     : cap_wr;
   assign uns   = (state == IDLE) ? reqUnsigned  : cap_uns;
   assign addr  = (state == IDLE) ? reqAddress   : cap_addr;
   assign wdata = (state == IDLE) ? reqWriteData : cap_wdata;
   assign size  = (state == IDLE) ? reqSize      : cap_size;

   assign lane = addr[LB-1:0];
   assign idx  = addr[IW+LB-1:LB];
   assign oor  = (addr >= LIMIT);
   assign err  = misal || oor;
   assign word = mem[idx];
   assign sh   = word >> {lane, 3'b000};
   assign wsh  = wdata << {lane, 3'b000};
   assign be   = sz_mask << lane;

   always_comb begin
      misal   = 1'b0;
      sz_mask = '1;
      ld      = sh;
      case (size)
         2'b00: begin
            sz_mask = NB'(1);
            ld      = {{(WIDTH-8){~uns & sh[7]}}, sh[7:0]};
         end
         2'b01: begin
            misal   = addr[0];
            sz_mask = NB'(3);
            ld      = {{(WIDTH-16){~uns & sh[15]}}, sh[15:0]};
         end
         2'b10: begin
            misal   = |addr[1:0];
            sz_mask = NB'(15);
            ld      = {{(WIDTH-32){~uns & sh[31]}}, sh[31:0]};
         end
         default: begin
            misal   = |addr[2:0];
            sz_mask = '1;
            ld      = sh;
         end
      endcase
   end

   for (genvar b = 0; b < NB; b++) begin : g_lane
      data_mem_byte_lane u_lane (
         .en    (be[b]),
         .new_b (wsh[8*b +: 8]),
         .old_b (word[8*b +: 8]),
         .out_b (wmerge[8*b +: 8])
      );
   end

   // Contents survive reset; a store lands only on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (commit && wr && !err) mem[idx] <= wmerge;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         live         <= 1'b0;
         cap_wr       <= 1'b0;
         cap_uns      <= 1'b0;
         cap_addr     <= '0;
         cap_wdata    <= '0;
         cap_size     <= 2'b00;
         respReadData <= '0;
         respError    <= 1'b0;
      end else begin
         live <= 1'b1;
         case (state)
            IDLE: if (acc) begin
               cap_wr    <= reqWrite;
               cap_uns   <= reqUnsigned;
               cap_addr  <= reqAddress;
               cap_wdata <= reqWriteData;
               cap_size  <= reqSize;
               if (LATENCY == 1) state <= RESP;
               else begin
                  state <= WAIT;
                  cnt   <= CNT_INIT;
               end
            end
            WAIT: if (cnt == 4'd0) state <= RESP;
                  else cnt <= cnt - 4'd1;
            RESP: if (respReady) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (commit) begin
            respReadData <= (err || wr) ? '0 : ld;
            respError    <= err;
         end else if ((state == RESP) && respReady) begin
            respReadData <= '0;
            respError    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Drives three responders (LATENCY 1, 2, 4) with identical traffic and checks
// them against a byte-array reference model.

module tb_data_mem_responder;
   logic        clk = 1'b0, rst = 1'b0;
   logic        reqValid = 1'b0, reqWrite = 1'b0, reqUnsigned = 1'b0, respReady = 1'b1;
   logic [63:0] reqAddress = '0, reqWriteData = '0;
   logic [1:0]  reqSize = 2'b00;
   logic [2:0]  rrdy, rvld, rerr;
   logic [63:0] rdat [3];

   int          ncmp = 0, nbad = 0;
   logic [7:0]  m [0:4095];
   logic [63:0] td [3];
   logic        te [3];
   int          lat [3];
   int          lat_exp [3] = '{1, 2, 4};

   always #5 clk = ~clk;

   data_mem_responder #(.LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(rrdy[0]), .reqWrite(reqWrite),
      .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqSize(reqSize),
      .reqUnsigned(reqUnsigned), .respValid(rvld[0]), .respReady(respReady),
      .respReadData(rdat[0]), .respError(rerr[0]));
   data_mem_responder u_l2 (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(rrdy[1]), .reqWrite(reqWrite),
      .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqSize(reqSize),
      .reqUnsigned(reqUnsigned), .respValid(rvld[1]), .respReady(respReady),
      .respReadData(rdat[1]), .respError(rerr[1]));
   data_mem_responder #(.LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(rrdy[2]), .reqWrite(reqWrite),
      .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqSize(reqSize),
      .reqUnsigned(reqUnsigned), .respValid(rvld[2]), .respReady(respReady),
      .respReadData(rdat[2]), .respError(rerr[2]));

   task automatic model(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input logic u,
                        output logic [63:0] rd, output logic er);
      int nb;
      logic [63:0] v;
      nb = 1 << sz;
      er = ((a % nb) != 0) || (a >= 64'd4096);
      rd = '0;
      if (!er) begin
         if (w) begin
            for (int i = 0; i < nb; i++) m[int'(a) + i] = d[8*i +: 8];
         end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = m[int'(a) + i];
            if (!u && nb < 8 && v[8*nb-1])
               for (int j = 8*nb; j < 64; j++) v[j] = 1'b1;
            rd = v;
         end
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (rrdy != 3'b111 && n < 50) begin
         @(negedge clk);
         n++;
      end
      ncmp++;
      if (rrdy != 3'b111) begin
         nbad++;
         $display("FAIL ready_timeout: reqReady=%b required 111", rrdy);
      end
   endtask

   task automatic txn(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [1:0] sz, input logic u, input bit chk);
      logic [63:0] erd;
      logic        eer;
      logic [2:0]  got;
      int          n;
      wait_ready();
      reqValid = 1'b1; reqWrite = w; reqAddress = a; reqWriteData = d;
      reqSize = sz; reqUnsigned = u;
      @(posedge clk); #1;
      reqValid = 1'b0; reqWrite = $urandom_range(0, 1); reqAddress = {$urandom, $urandom};
      reqWriteData = {$urandom, $urandom}; reqSize = 2'($urandom); reqUnsigned = $urandom_range(0, 1);
      n = 1; got = '0;
      while (got != 3'b111 && n < 40) begin
         for (int k = 0; k < 3; k++)
            if (!got[k] && rvld[k]) begin
               got[k] = 1'b1; lat[k] = n; td[k] = rdat[k]; te[k] = rerr[k];
            end
         if (got != 3'b111) begin
            @(posedge clk); #1;
            n++;
         end
      end
      ncmp++;
      if (got != 3'b111) begin
         nbad++;
         $display("FAIL resp_timeout: got=%b required 111", got);
      end
      if (chk) begin
         model(w, a, d, sz, u, erd, eer);
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (td[k] !== erd || te[k] !== eer || lat[k] != lat_exp[k]) begin
               nbad++;
               $display("FAIL txn[L%0d] w=%b a=%h sz=%0d u=%b: data=%h err=%b lat=%0d required data=%h err=%b lat=%0d",
                        lat_exp[k], w, a, sz, u, td[k], te[k], lat[k], erd, eer, lat_exp[k]);
            end
         end
      end
   endtask

   task automatic test_reset();
      respReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         ncmp++;
         if (rrdy[k] !== 1'b0 || rvld[k] !== 1'b0 || rdat[k] !== 64'd0 || rerr[k] !== 1'b0) begin
            nbad++;
            $display("FAIL reset_state[L%0d]: rdy=%b vld=%b data=%h err=%b required 0 0 0 0",
                     lat_exp[k], rrdy[k], rvld[k], rdat[k], rerr[k]);
         end
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      ncmp++;
      if (rrdy !== 3'b111) begin
         nbad++;
         $display("FAIL reset_release: reqReady=%b required 111", rrdy);
      end
   endtask

   task automatic test_prefill();
      for (int i = 0; i < 8; i++) txn(1'b1, 64'(8*i), {$urandom, $urandom}, 2'b11, 1'b0, 1'b1);
   endtask

   task automatic test_directed();
      txn(1'b1, 64'h10, 64'h1122334455667788, 2'b11, 1'b0, 1'b1);
      txn(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
      ncmp++;
      if (td[1] !== 64'h1122334455667788 || te[1] !== 1'b0) begin
         nbad++; $display("FAIL ld_double: data=%h err=%b required 1122334455667788 0", td[1], te[1]);
      end
      txn(1'b0, 64'h17, 64'd0, 2'b00, 1'b0, 1'b1);
      ncmp++;
      if (td[1] !== 64'h11) begin
         nbad++; $display("FAIL ld_byte_17: data=%h required 11", td[1]);
      end
      txn(1'b1, 64'h13, 64'hF0, 2'b00, 1'b0, 1'b1);
      txn(1'b0, 64'h10, 64'd0, 2'b10, 1'b0, 1'b1);
      ncmp++;
      if (td[1] !== 64'hFFFFFFFFF0667788) begin
         nbad++; $display("FAIL ld_word_signed: data=%h required fffffffff0667788", td[1]);
      end
      txn(1'b0, 64'h10, 64'd0, 2'b10, 1'b1, 1'b1);
      ncmp++;
      if (td[1] !== 64'h00000000F0667788) begin
         nbad++; $display("FAIL ld_word_unsigned: data=%h required 00000000f0667788", td[1]);
      end
      txn(1'b0, 64'h11, 64'd0, 2'b01, 1'b0, 1'b1);
      ncmp++;
      if (te[1] !== 1'b1 || td[1] !== 64'd0) begin
         nbad++; $display("FAIL ld_half_misaligned: data=%h err=%b required 0 1", td[1], te[1]);
      end
      txn(1'b1, 64'h1000, 64'hDEADBEEFCAFEF00D, 2'b11, 1'b0, 1'b1);
      ncmp++;
      if (te[1] !== 1'b1) begin
         nbad++; $display("FAIL st_out_of_range: err=%b required 1", te[1]);
      end
      txn(1'b0, 64'h0, 64'd0, 2'b11, 1'b0, 1'b1);
      txn(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, 1'b1);
      txn(1'b1, 64'hFF8, 64'h0123456789ABCDEF, 2'b11, 1'b0, 1'b1);
      txn(1'b0, 64'hFFF, 64'd0, 2'b00, 1'b0, 1'b1);
      txn(1'b0, 64'hFFE, 64'd0, 2'b01, 1'b1, 1'b1);
   endtask

   task automatic test_backpressure();
      logic [63:0] d0, erd;
      logic        eer;
      int          n;
      wait_ready();
      respReady = 1'b0;
      reqValid = 1'b1; reqWrite = 1'b0; reqAddress = 64'h10; reqSize = 2'b11; reqUnsigned = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b0; reqAddress = 64'h18;
      n = 1;
      while (!rvld[1] && n < 10) begin
         @(posedge clk); #1; n++;
      end
      d0 = rdat[1];
      model(1'b0, 64'h10, 64'd0, 2'b11, 1'b0, erd, eer);
      ncmp++;
      if (d0 !== erd || !rvld[1]) begin
         nbad++; $display("FAIL bp_first: vld=%b data=%h required 1 %h", rvld[1], d0, erd);
      end
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         ncmp++;
         if (rvld[1] !== 1'b1 || rdat[1] !== d0 || rrdy[1] !== 1'b0) begin
            nbad++;
            $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy=%b required 1 %h 0", c, rvld[1], rdat[1], rrdy[1], d0);
         end
      end
      @(negedge clk); respReady = 1'b1;
      @(posedge clk); #1;
      ncmp++;
      if (rrdy[1] !== 1'b1 || rvld[1] !== 1'b0) begin
         nbad++; $display("FAIL bp_release: rdy=%b vld=%b required 1 0", rrdy[1], rvld[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] prior;
      prior = m[32];
      wait_ready();
      reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 64'h20; reqWriteData = 64'hAA;
      reqSize = 2'b00; reqUnsigned = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(negedge clk); rst = 1'b0;
      #1;
      ncmp++;
      if (rvld !== 3'b000 || rrdy !== 3'b000) begin
         nbad++; $display("FAIL rst_mid_hold: vld=%b rdy=%b required 000 000", rvld, rrdy);
      end
      repeat (2) @(posedge clk);
      #1;
      ncmp++;
      if (rvld !== 3'b000) begin
         nbad++; $display("FAIL rst_mid_noresp: vld=%b required 000", rvld);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      ncmp++;
      if (rrdy !== 3'b111) begin
         nbad++; $display("FAIL rst_mid_release: reqReady=%b required 111", rrdy);
      end
      txn(1'b0, 64'h20, 64'd0, 2'b00, 1'b1, 1'b0);
      ncmp++;
      // LATENCY=1 commits on the accept edge, before the reset lands.
      if (td[0] !== 64'hAA || td[1] !== {56'd0, prior} || td[2] !== {56'd0, prior}) begin
         nbad++;
         $display("FAIL rst_mid_byte: data=%h %h %h required %h %h %h", td[0], td[1], td[2],
                  64'hAA, {56'd0, prior}, {56'd0, prior});
      end
      txn(1'b1, 64'h20, {56'd0, prior}, 2'b00, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [63:0] a;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 9) == 0) a = 64'(4096 + $urandom_range(0, 64));
         else a = 64'($urandom_range(0, 63));
         txn($urandom_range(0, 1), a, {$urandom, $urandom}, 2'($urandom), $urandom_range(0, 1), 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_prefill();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data and address width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, number of WIDTH-bit memory words.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to response valid (legal range 1..15).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port reqValid, input, 1 bit: core presents a request.
REQ-007 SHALL have port reqReady, output, 1 bit: responder can accept a request.
REQ-008 SHALL have port reqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port reqAddress, input, WIDTH bits: byte address.
REQ-010 SHALL have port reqWriteData, input, WIDTH bits: store data, right-aligned.
REQ-011 SHALL have port reqSize, input, 2 bits: 00 byte, 01 half, 10 word, 11 double.
REQ-012 SHALL have port reqUnsigned, input, 1 bit: load zero-extends when 1, sign-extends when 0.
REQ-013 SHALL have port respValid, output, 1 bit: response present.
REQ-014 SHALL have port respReady, input, 1 bit: core accepts the response.
REQ-015 SHALL have port respReadData, output, WIDTH bits: load result, extended to WIDTH.
REQ-016 SHALL have port respError, output, 1 bit: request was misaligned or out of range.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP, with one outstanding request maximum.
REQ-018 SHALL drive reqReady = 1 only in IDLE and respValid = 1 only in RESP.
REQ-019 SHALL accept a request on a rising edge where reqValid && reqReady, capture all req* fields, and move to WAIT (or directly to RESP when LATENCY = 1).
REQ-020 SHALL hold WAIT with a down-counter so that respValid rises exactly LATENCY cycles after the accept edge.
REQ-021 SHALL hold RESP, with respReadData and respError stable, until respReady = 1; the handshake edge returns the FSM to IDLE; a new request is accepted no earlier than the following edge.
REQ-022 SHALL treat the memory as little-endian: word index = reqAddress >> 3, byte lane = reqAddress[2:0].
REQ-023 SHALL flag an error when the address is not a multiple of the access size, or when reqAddress >= DEPTH*8.
REQ-024 SHALL, on error, leave memory unmodified and return respReadData = 0, respError = 1.
REQ-025 SHALL commit a legal store on the edge entering RESP, writing only the addressed bytes; respReadData = 0 for stores.
REQ-026 SHALL, for a legal load, extract the addressed lane and sign- or zero-extend it per reqUnsigned; reqUnsigned is ignored for size 11.
REQ-027 SHALL ignore req* changes while not in IDLE, and SHALL ignore respReady outside RESP.

Reset
REQ-028 SHALL, while rst = 0, force the FSM to IDLE, the counter to 0, reqReady = 0, respValid = 0, respReadData = 0, and respError = 0.
REQ-029 SHALL assert reqReady on the first rising edge after rst deasserts.
REQ-030 SHALL, if reset occurs mid-operation, drop the pending request with no response; a store not yet committed SHALL NOT be written.
REQ-031 SHALL NOT reset memory contents.

Verification
REQ-032 Store double 0x1122334455667788 at 0x10, then load double at 0x10 -> respReadData = 0x1122334455667788, respError = 0, respValid rises 2 cycles after accept.
REQ-033 From the state of REQ-032, load byte at 0x17 signed -> 0x0000000000000011; store byte 0xF0 at 0x13, then load word at 0x10 signed -> 0xFFFFFFFFF0667788 (word bytes become 88 77 66 F0), and load word at 0x10 unsigned -> 0x00000000F0667788.
REQ-034 Load half at 0x11 -> respError = 1, respReadData = 0; store double at 0x1000 (DEPTH = 512) -> respError = 1, memory unchanged.
REQ-035 Hold respReady = 0 for 5 cycles in RESP -> respValid and respReadData stay stable and reqReady stays 0; respReady = 1 -> IDLE, reqReady = 1 on the next cycle.
REQ-036 Assert rst low one cycle after accepting a store of 0xAA to byte 0x20 -> no response, byte 0x20 keeps its prior value, reqReady = 1 one edge after release.
REQ-037 Rerun REQ-032 with LATENCY = 1 and LATENCY = 4 -> respValid rises exactly 1 and 4 cycles after accept, respectively.
